mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store alignment unit in the MEM stage, between the EX/MEM pipeline register and the word-addressed data memory.
- Converts byte addresses and access sizes into word accesses.
- Performs sub-word stores as a registered read-modify-write, which costs one stall cycle.
- Extracts and sign/zero-extends sub-word load data, and flags misaligned or out-of-range accesses.

Parameters:
- PC_BITS, 32, data/address width (shared package constant).
- SIZE_MEMORY, 1024, data memory depth in words (shared package constant).
- BIG_ENDIAN, 1, 1: byte offset 0 maps to bits [31:24]; 0: byte offset 0 maps to bits [7:0].

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_m  in  1  EX/MEM slot holds a live instruction.
- flush_m  in  1  kill the current MEM-stage instruction.
- mem_read_m  in  1  load.
- mem_write_m  in  1  store.
- mem_size_m  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as fault).
- mem_unsigned_m  in  1  zero-extend loads (lbu/lhu).
- alu_out_m  in  PC_BITS  byte address.
- write_data_m  in  PC_BITS  store data, right-justified.
- dm_read_data  in  PC_BITS  combinational read word from data memory.
- dm_addr  out  PC_BITS  word index to data memory.
- dm_write_data  out  PC_BITS  word to write.
- dm_write_en  out  1  data memory write strobe.
- load_data_m  out  PC_BITS  aligned, extended load result.
- stall_m  out  1  hold EX/MEM and earlier stages.
- fault_m  out  1  access fault for this instruction.
- fault_cause_m  out  2  00 none, 01 misaligned, 10 out-of-range, 11 bad size.

Behaviour:
- Reset values:
  - FSM state = IDLE; merge_word_q = 0; merge_addr_q = 0.
  - dm_write_en = 0; stall_m = 0; fault_m = 0; fault_cause_m = 00.
  - load_data_m = 0; dm_addr = 0; dm_write_data = 0.
- Word index = alu_out_m >> 2; offset = alu_out_m[1:0].
- Access is "active" when valid_m & ~flush_m & (mem_read_m | mem_write_m).
- Fault rules (combinational, IDLE state only; priority is bad size > misaligned > out-of-range):
  - Bad size: mem_size_m = 11.
  - Misaligned: half with offset[0] = 1, or word with offset != 0.
  - Out-of-range: word index >= SIZE_MEMORY.
- A faulting access never writes, never stalls, and returns load_data_m = 0.
- mem_read_m and mem_write_m both high is a bad-size fault.
- FSM states:
  - IDLE:
    - Word store, no fault: dm_write_en = 1 in the same cycle; dm_addr = word index; dm_write_data = write_data_m; no stall.
    - Sub-word store, no fault: merge_word_q <= (dm_read_data & ~mask) | (lane-shifted write_data_m & mask); merge_addr_q <= word index; stall_m = 1; next state WRITE; dm_write_en = 0.
    - Load: dm_addr = word index; load_data_m = selected lane, sign- or zero-extended per mem_unsigned_m; 0 latency; no stall.
    - Otherwise: outputs idle and dm_addr = word index.
  - WRITE:
    - dm_addr = merge_addr_q; dm_write_data = merge_word_q; dm_write_en = ~flush_m; stall_m = 0.
    - EX/MEM inputs still show the same held store and are ignored.
    - Next state is always IDLE.
    - flush_m in WRITE aborts the write with no memory change.
- Reset during WRITE: the write is dropped and the FSM returns to IDLE asynchronously.
- Masks (BIG_ENDIAN = 1):
  - byte at offset k: bits [31-8k -: 8];
  - half at offset 0: [31:16]; at offset 2: [15:0].
- Back-to-back sub-word stores: each costs exactly one stall cycle.
- A load following a store sees the written word, because the memory write completes at the clock edge before the load's cycle.
- Each stall lasts exactly one cycle; stall_m is never asserted in two consecutive cycles for one instruction.

Decomposition:
- CPU_def package holds:
  - PC_BITS and SIZE_MEMORY;
  - a mem_size_t enum {MS_BYTE, MS_HALF, MS_WORD, MS_BAD};
  - a fault_cause_t enum;
  - a lsu_state_t enum {IDLE, WRITE}.
- One combinational sub-module, lane_align, provides both directions of lane steering:
  - store path: mask and shifted data from offset/size;
  - load path: lane extract plus sign/zero extend.
  - It is instantiated for both paths.

Test Plan:
- Word store 0xDEADBEEF to byte addr 0x10, then word load from 0x10 -> dm_write_en is high for 1 cycle with dm_addr = 4; the load returns 0xDEADBEEF; stall_m is never asserted.
- Memory[4] = 0x11223344; sb 0xAB to addr 0x11 -> stall_m high for 1 cycle, then a write of 0x11AB3344; lb from 0x11 -> 0xFFFFFFAB; lbu from 0x11 -> 0x000000AB.
- sh 0x8001 to addr 0x12 over 0x11223344 -> writes 0x11228001; lh from 0x12 -> 0xFFFF8001; lhu from 0x12 -> 0x00008001.
- lw from 0x13 -> fault_m = 1 with cause 01, load_data_m = 0; sh to 0x11 -> cause 01, no dm_write_en; addr = 4*SIZE_MEMORY -> cause 10, no write.
- sb to 0x20, with flush_m asserted in the WRITE cycle -> no dm_write_en and memory unchanged; rst asserted mid-WRITE -> FSM returns to IDLE and all outputs take their reset values.
- Two consecutive sb to 0x20 and 0x21 -> exactly 2 stall cycles total and final word 0xAABBxxxx with low bytes preserved.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared CPU constants and types for the MEM-stage load/store path.
package mem_access_unit_pkg;

  localparam int PC_BITS     = 32;
  localparam int SIZE_MEMORY = 1024;

  typedef enum logic [1:0] {
    MS_BYTE = 2'b00,
    MS_HALF = 2'b01,
    MS_WORD = 2'b10,
    MS_BAD  = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_RANGE    = 2'b10,
    FC_BAD_SIZE = 2'b11
  } fault_cause_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: store mask/shift and load extract with sign/zero extension.
module lane_align
  import mem_access_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]         offset_i,
  input  mem_size_t          size_i,
  input  logic               unsigned_i,
  input  logic [PC_BITS-1:0] store_data_i,
  input  logic [PC_BITS-1:0] load_word_i,
  output logic [PC_BITS-1:0] mask_o,
  output logic [PC_BITS-1:0] store_shifted_o,
  output logic [PC_BITS-1:0] load_data_o
);

  function automatic logic [PC_BITS-1:0] extend8(input logic [7:0] b, input logic uns);
    logic signed [7:0]         sb;
    logic signed [PC_BITS-1:0] sx;
    sb = b;
    sx = sb;
    return uns ? {{(PC_BITS-8){1'b0}}, b} : sx;
  endfunction

  function automatic logic [PC_BITS-1:0] extend16(input logic [15:0] h, input logic uns);
    logic signed [15:0]        sh;
    logic signed [PC_BITS-1:0] sx;
    sh = h;
    sx = sh;
    return uns ? {{(PC_BITS-16){1'b0}}, h} : sx;
  endfunction

  logic [4:0]         shamt;
  logic [PC_BITS-1:0] base_mask;
  logic [PC_BITS-1:0] lane;

  // Big-endian: lower byte offsets sit in more significant lanes.
  always_comb begin
    shamt     = 5'd0;
    base_mask = '0;
    case (size_i)
      MS_BYTE: begin
        shamt     = BIG_ENDIAN ? {~offset_i, 3'b000} : {offset_i, 3'b000};
        base_mask = {{(PC_BITS-8){1'b0}}, 8'hFF};
      end
      MS_HALF: begin
        shamt     = BIG_ENDIAN ? {~offset_i[1], 4'b0000} : {offset_i[1], 4'b0000};
        base_mask = {{(PC_BITS-16){1'b0}}, 16'hFFFF};
      end
      MS_WORD: base_mask = '1;
      default: base_mask = '0;
    endcase
  end

  assign mask_o          = base_mask << shamt;
  assign store_shifted_o = (store_data_i << shamt) & mask_o;
  assign lane            = load_word_i >> shamt;

  always_comb begin
    case (size_i)
      MS_BYTE: load_data_o = extend8(lane[7:0], unsigned_i);
      MS_HALF: load_data_o = extend16(lane[15:0], unsigned_i);
      MS_WORD: load_data_o = lane;
      default: load_data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store alignment unit; sub-word stores use a one-stall read-modify-write.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_m,
  input  logic               flush_m,
  input  logic               mem_read_m,
  input  logic               mem_write_m,
  input  logic [1:0]         mem_size_m,
  input  logic               mem_unsigned_m,
  input  logic [PC_BITS-1:0] alu_out_m,
  input  logic [PC_BITS-1:0] write_data_m,
  input  logic [PC_BITS-1:0] dm_read_data,
  output logic [PC_BITS-1:0] dm_addr,
  output logic [PC_BITS-1:0] dm_write_data,
  output logic               dm_write_en,
  output logic [PC_BITS-1:0] load_data_m,
  output logic               stall_m,
  output logic               fault_m,
  output logic [1:0]         fault_cause_m
);

  lsu_state_t         state_q, state_d;
  logic [PC_BITS-1:0] merge_word_q, merge_word_d;
  logic [PC_BITS-1:0] merge_addr_q, merge_addr_d;

  logic [PC_BITS-1:0] word_idx;
  logic [1:0]         offset;
  mem_size_t          size;
  logic               active;
  fault_cause_t       cause;
  logic [PC_BITS-1:0] lane_mask;
  logic [PC_BITS-1:0] lane_store;
  logic [PC_BITS-1:0] lane_load;

  assign word_idx = {2'b00, alu_out_m[PC_BITS-1:2]};
  assign offset   = alu_out_m[1:0];
  assign size     = mem_size_t'(mem_size_m);
  assign active   = valid_m & ~flush_m & (mem_read_m | mem_write_m);

  lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane_align (
    .offset_i        (offset),
    .size_i          (size),
    .unsigned_i      (mem_unsigned_m),
    .store_data_i    (write_data_m),
    .load_word_i     (dm_read_data),
    .mask_o          (lane_mask),
    .store_shifted_o (lane_store),
    .load_data_o     (lane_load)
  );

  // A simultaneous read and write is malformed and reported as a bad size.
  always_comb begin
    cause = FC_NONE;
    if (size == MS_BAD || (mem_read_m && mem_write_m))
      cause = FC_BAD_SIZE;
    else if ((size == MS_HALF && offset[0]) || (size == MS_WORD && offset != 2'b00))
      cause = FC_MISALIGN;
    else if (word_idx >= PC_BITS'(SIZE_MEMORY))
      cause = FC_RANGE;
  end

  always_comb begin
    state_d       = state_q;
    merge_word_d  = merge_word_q;
    merge_addr_d  = merge_addr_q;
    dm_addr       = word_idx;
    dm_write_data = '0;
    dm_write_en   = 1'b0;
    load_data_m   = '0;
    stall_m       = 1'b0;
    fault_m       = 1'b0;
    fault_cause_m = FC_NONE;
    if (rst) begin
      dm_addr = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (active) begin
            if (cause != FC_NONE) begin
              fault_m       = 1'b1;
              fault_cause_m = cause;
            end else if (mem_write_m) begin
              if (size == MS_WORD) begin
                dm_write_en   = 1'b1;
                dm_write_data = write_data_m;
              end else begin
                merge_word_d = (dm_read_data & ~lane_mask) | (lane_store & lane_mask);
                merge_addr_d = word_idx;
                stall_m      = 1'b1;
                state_d      = WRITE;
              end
            end else begin
              load_data_m = lane_load;
            end
          end
        end
        // The held store on the EX/MEM inputs is ignored here; only flush matters.
        WRITE: begin
          dm_addr       = merge_addr_q;
          dm_write_data = merge_word_q;
          dm_write_en   = ~flush_m;
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      merge_word_q <= '0;
      merge_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      merge_word_q <= merge_word_d;
      merge_addr_q <= merge_addr_d;
    end
  end

endmodule
